mem_req_arbiter: RTL and testbench

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

---
 rtl/mem_req_arbiter_pkg.sv | 13 +
 rtl/mem_req_arbiter_wq_fifo.sv | 74 +++++++
 rtl/mem_req_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_req_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_arbiter_pkg.sv
// Shared memory-side definitions: default bus widths and the read FSM state encoding.
package mem_req_arbiter_pkg;

  localparam int unsigned MEM_WIDTH = 16;
  localparam int unsigned MEM_PSIZE = 4;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_WAIT = 2'd1,
    RD_HOLD = 2'd2
  } rd_state_t;

endpackage

// File: rtl/mem_req_arbiter_wq_fifo.sv
// Write queue: DEPTH-entry {addr,data} FIFO with an address-match lookup over live entries.
module mem_wq_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned PSIZE = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [PSIZE-1:0] i_push_addr,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  input  logic [PSIZE-1:0] i_lookup_addr,
  output logic [PSIZE-1:0] o_head_addr,
  output logic [WIDTH-1:0] o_head_data,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_match
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PSIZE-1:0] r_addr [DEPTH];
  logic [WIDTH-1:0] r_data [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic             w_match;

  assign o_empty     = (r_count == CW'(0));
  assign o_full      = (r_count == CW'(DEPTH));
  // A full queue still takes a push when the head leaves in the same cycle.
  assign w_push_ok   = i_push && (!o_full || i_pop);
  assign w_pop_ok    = i_pop && !o_empty;
  assign o_head_addr = r_addr[r_rptr];
  assign o_head_data = r_data[r_rptr];
  assign o_match     = w_match;

  // Entry storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_addr[r_wptr] <= i_push_addr;
      r_data[r_wptr] <= i_push_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; the count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + PW'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + PW'(1);
      if (w_push_ok && !w_pop_ok)      r_count <= r_count + CW'(1);
      else if (w_pop_ok && !w_push_ok) r_count <= r_count - CW'(1);
    end
  end

  // Any live entry (offset from head below count) holding the lookup address.
  always_comb begin
    w_match = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if ((CW'(PW'(PW'(i) - r_rptr)) < r_count) && (r_addr[i] == i_lookup_addr)) begin
        w_match = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates a queued write stream and a single-outstanding read stream onto one storage port.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH    = MEM_WIDTH,
  parameter int unsigned PSIZE    = MEM_PSIZE,
  parameter int unsigned WQ_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [PSIZE-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_valid,
  output logic             rd_ready,
  input  logic [PSIZE-1:0] rd_addr,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             mem_wr,
  output logic             mem_rd,
  output logic [PSIZE-1:0] mem_wr_addr,
  output logic [PSIZE-1:0] mem_rd_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  rd_state_t        r_state;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_valid;
  logic             r_prio_wr;
  logic             w_empty;
  logic             w_full;
  logic             w_match;
  logic [PSIZE-1:0] w_head_addr;
  logic [WIDTH-1:0] w_head_data;
  logic             w_push;
  logic             w_rd_elig;
  logic             w_grant_wr;
  logic             w_grant_rd;

  mem_wq_fifo #(
    .WIDTH (WIDTH),
    .PSIZE (PSIZE),
    .DEPTH (WQ_DEPTH)
  ) u_wq (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_push        (w_push),
    .i_push_addr   (wr_addr),
    .i_push_data   (wr_data),
    .i_pop         (w_grant_wr),
    .i_lookup_addr (rd_addr),
    .o_head_addr   (w_head_addr),
    .o_head_data   (w_head_data),
    .o_empty       (w_empty),
    .o_full        (w_full),
    .o_match       (w_match)
  );

  assign wr_ready    = rst_n && !w_full;
  assign w_push      = wr_valid && wr_ready;
  // A read may not overtake a queued write to the same address.
  assign w_rd_elig   = rst_n && rd_valid && (r_state == RD_IDLE) && !w_match;

  assign mem_wr      = w_grant_wr;
  assign mem_rd      = w_grant_rd;
  assign rd_ready    = w_grant_rd;
  assign mem_wr_addr = w_head_addr;
  assign mem_wdata   = w_head_data;
  assign mem_rd_addr = rd_addr;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;

  // Single grant per cycle: full queue forces a write, otherwise round-robin on contention.
  always_comb begin
    w_grant_wr = 1'b0;
    w_grant_rd = 1'b0;
    if (!w_empty && (w_full || !w_rd_elig || r_prio_wr)) begin
      w_grant_wr = 1'b1;
    end else if (w_rd_elig) begin
      w_grant_rd = 1'b1;
    end
  end

  // Read FSM, response register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RD_IDLE;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
      r_prio_wr   <= 1'b1;
    end else begin
      if (w_grant_wr)      r_prio_wr <= 1'b0;
      else if (w_grant_rd) r_prio_wr <= 1'b1;

      case (r_state)
        RD_IDLE: begin
          if (w_grant_rd) r_state <= RD_WAIT;
        end
        RD_WAIT: begin
          r_state     <= RD_HOLD;
          r_rsp_data  <= mem_rdata;
          r_rsp_valid <= 1'b1;
        end
        RD_HOLD: begin
          if (rsp_ready) begin
            r_state     <= RD_IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= RD_IDLE;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter with a registered-read storage model.
module tb_mem_req_arbiter;

  logic        clk;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [3:0]  rd_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        mem_wr;
  logic        mem_rd;
  logic [3:0]  mem_wr_addr;
  logic [3:0]  mem_rd_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic [15:0] mem_model [16];
  int          n_checks;
  int          n_pass;

  logic [14:0] exp_rd;
  logic [14:0] exp_wr;
  logic [14:0] exp_rdy;
  logic [15:0] exp_tail [3];

  mem_req_arbiter #(
    .WIDTH    (16),
    .PSIZE    (4),
    .WQ_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_addr     (rd_addr),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .mem_wr      (mem_wr),
    .mem_rd      (mem_rd),
    .mem_wr_addr (mem_wr_addr),
    .mem_rd_addr (mem_rd_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Storage model: registered read; returns a junk pattern in cycles with no read.
  always @(posedge clk) begin
    if (mem_wr) mem_model[mem_wr_addr] <= mem_wdata;
    mem_rdata <= mem_rd ? mem_model[mem_rd_addr] : 16'hDEAD;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    for (int i = 0; i < 16; i++) mem_model[i] = 16'h0000;
    mem_rdata = 16'h0000;
    // Contention table, bit index = cycle number.
    exp_rd  = 15'b001_001_001_001_001;
    exp_wr  = 15'b110_110_110_110_110;
    exp_rdy = 15'b101_101_111_111_111;
    exp_tail[0] = 16'h010B;
    exp_tail[1] = 16'h010C;
    exp_tail[2] = 16'h010E;

    // Reset with requests offered: nothing may be accepted or issued.
    rst_n     = 1'b1;
    wr_valid  = 1'b1;
    wr_addr   = 4'd0;
    wr_data   = 16'h0;
    rd_valid  = 1'b1;
    rd_addr   = 4'd0;
    rsp_ready = 1'b1;
    #1 rst_n  = 1'b0;
    #1;
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    next_cycle();
    next_cycle();
    rst_n    = 1'b1;
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    #1;
    check("rel_wr_ready", 32'(wr_ready), 32'd1);
    check("rel_rsp_data", 32'(rsp_data), 32'd0);
    next_cycle();

    // Single write.
    wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 16'h1234;
    #1;
    check("w1_no_issue_yet", 32'(mem_wr), 32'd0);
    next_cycle();
    wr_valid = 1'b0;
    #1;
    check("w1_mem_wr", 32'(mem_wr), 32'd1);
    check("w1_addr", 32'(mem_wr_addr), 32'd3);
    check("w1_data", 32'(mem_wdata), 32'h1234);
    next_cycle();
    #1;
    check("w1_drained", 32'(mem_wr), 32'd0);
    check("w1_wr_ready", 32'(wr_ready), 32'd1);

    // Read-after-write to the same address waits for the write.
    wr_valid = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF;
    next_cycle();
    wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 4'd5;
    #1;
    check("raw_blocked_rd", 32'(mem_rd), 32'd0);
    check("raw_blocked_ready", 32'(rd_ready), 32'd0);
    check("raw_write_first", 32'(mem_wr), 32'd1);
    next_cycle();
    #1;
    check("raw_rd_issue", 32'(mem_rd), 32'd1);
    check("raw_rd_ready", 32'(rd_ready), 32'd1);
    check("raw_rd_addr", 32'(mem_rd_addr), 32'd5);
    next_cycle();
    rd_valid = 1'b0;
    #1;
    check("raw_wait_no_rsp", 32'(rsp_valid), 32'd0);
    next_cycle();
    #1;
    check("raw_rsp_valid", 32'(rsp_valid), 32'd1);
    check("raw_rsp_data", 32'(rsp_data), 32'hBEEF);
    next_cycle();
    #1;
    check("raw_rsp_done", 32'(rsp_valid), 32'd0);

    // Continuous writes to 1 and reads to 2: round-robin, then the queue fills.
    for (int c = 0; c < 15; c++) begin
      wr_valid = 1'b1; wr_addr = 4'd1; wr_data = 16'h0100 + 16'(c);
      rd_valid = 1'b1; rd_addr = 4'd2;
      #1;
      check($sformatf("cont_mem_rd_c%0d", c), 32'(mem_rd), 32'(exp_rd[c]));
      check($sformatf("cont_mem_wr_c%0d", c), 32'(mem_wr), 32'(exp_wr[c]));
      check($sformatf("cont_wr_ready_c%0d", c), 32'(wr_ready), 32'(exp_rdy[c]));
      check($sformatf("cont_exclusive_c%0d", c), 32'(mem_wr && mem_rd), 32'd0);
      if (c == 1) check("cont_head_data", 32'(mem_wdata), 32'h0100);
      next_cycle();
    end

    // Drain: remaining queued writes issue back-to-back in order.
    wr_valid = 1'b0; rd_valid = 1'b0;
    for (int d = 0; d < 3; d++) begin
      #1;
      check($sformatf("drain_mem_wr_%0d", d), 32'(mem_wr), 32'd1);
      check($sformatf("drain_data_%0d", d), 32'(mem_wdata), 32'(exp_tail[d]));
      next_cycle();
    end
    #1;
    check("drain_empty", 32'(mem_wr), 32'd0);
    next_cycle();

    // Response held under backpressure.
    wr_valid = 1'b1; wr_addr = 4'd7; wr_data = 16'hA5A5;
    next_cycle();
    wr_valid = 1'b0;
    #1;
    check("hold_pre_wr_data", 32'(mem_wdata), 32'hA5A5);
    next_cycle();
    rd_valid = 1'b1; rd_addr = 4'd7; rsp_ready = 1'b0;
    #1;
    check("hold_rd_issue", 32'(mem_rd), 32'd1);
    next_cycle();
    #1;
    check("hold_wait_no_rd", 32'(mem_rd), 32'd0);
    next_cycle();
    for (int h = 0; h < 3; h++) begin
      #1;
      check($sformatf("hold_valid_%0d", h), 32'(rsp_valid), 32'd1);
      check($sformatf("hold_data_%0d", h), 32'(rsp_data), 32'hA5A5);
      check($sformatf("hold_no_rd_%0d", h), 32'(mem_rd), 32'd0);
      next_cycle();
    end
    rsp_ready = 1'b1;
    #1;
    check("hold_accept_valid", 32'(rsp_valid), 32'd1);
    check("hold_accept_no_rd", 32'(mem_rd), 32'd0);
    next_cycle();
    wr_valid = 1'b1; wr_addr = 4'd9; wr_data = 16'h5555;
    #1;
    check("hold_next_rd", 32'(mem_rd), 32'd1);
    next_cycle();

    // Reset while the read is in WAIT with a write queued.
    wr_valid = 1'b0; rd_valid = 1'b0;
    #1;
    check("rstw_pre_mem_wr", 32'(mem_wr), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstw_mem_wr", 32'(mem_wr), 32'd0);
    check("rstw_wr_ready", 32'(wr_ready), 32'd0);
    check("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    for (int r = 0; r < 3; r++) begin
      #1;
      check($sformatf("rstw_post_rsp_%0d", r), 32'(rsp_valid), 32'd0);
      check($sformatf("rstw_post_empty_%0d", r), 32'(mem_wr), 32'd0);
      check($sformatf("rstw_post_ready_%0d", r), 32'(wr_ready), 32'd1);
      next_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
